// File: rtl/imm_pkg.sv
// imm_pkg: immediate-format encodings, error codes, field masks and the decode-side immediate extender
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_ALIGN   = 2'b10,
        ERR_ILLEGAL = 2'b11
    } imm_err_e;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;

    // Same extraction the decoder performs; used to prove an encoded word round-trips
    function automatic logic [31:0] imm_extend(input logic [31:0] w, input logic [2:0] src);
        return (src == IMM_I) ? {{20{w[31]}}, w[31:20]} :
               (src == IMM_S) ? {{20{w[31]}}, w[31:25], w[11:7]} :
               (src == IMM_B) ? {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} :
               (src == IMM_J) ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} :
               (src == IMM_U) ? {w[31:12], 12'h000} : 32'h0;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: merges an immediate into the selected format's instruction fields and flags unrepresentable values
module imm_pack
    import imm_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  src_i,
    output logic [31:0] instr_o,
    output logic [1:0]  err_o
);

    logic [31:0] mask;
    logic [31:0] field;
    logic        range_bad;
    logic        align_bad;
    logic        illegal;

    // Select mask/field per format, then clear the fields and insert the immediate only when it is legal
    always_comb begin
        mask      = 32'h0;
        field     = 32'h0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        illegal   = 1'b0;
        case (src_i)
            IMM_I: begin
                mask      = MASK_I;
                field     = {imm_i[11:0], 20'h0};
                range_bad = imm_i[31:11] != {21{imm_i[31]}};
            end
            IMM_S: begin
                mask      = MASK_S;
                field     = {imm_i[11:5], 13'h0, imm_i[4:0], 7'h0};
                range_bad = imm_i[31:11] != {21{imm_i[31]}};
            end
            IMM_B: begin
                mask      = MASK_B;
                field     = {imm_i[12], imm_i[10:5], 13'h0, imm_i[4:1], imm_i[11], 7'h0};
                range_bad = imm_i[31:12] != {20{imm_i[31]}};
                align_bad = imm_i[0];
            end
            IMM_J: begin
                mask      = MASK_J;
                field     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h0};
                range_bad = imm_i[31:20] != {12{imm_i[31]}};
                align_bad = imm_i[0];
            end
            IMM_U: begin
                mask      = MASK_U;
                field     = {imm_i[31:12], 12'h0};
                align_bad = |imm_i[11:0];
            end
            default: illegal = 1'b1;
        endcase
        err_o   = illegal ? ERR_ILLEGAL : align_bad ? ERR_ALIGN : range_bad ? ERR_RANGE : ERR_OK;
        instr_o = (instr_i & ~mask) | ((err_o == ERR_OK) ? field : 32'h0);
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready immediate encoder; IMM_ENCODER_SELFCHECK_EN adds a round-trip check driving chk_fail
module imm_encoder
    import imm_pkg::*;
#(
    parameter bit PIPE_BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_immsrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_err,
    output logic        chk_fail
);

    logic [31:0] pk_instr;
    logic [1:0]  pk_err;
    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [1:0]  s1_err;
    logic        s2_adv;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [1:0]  out_err_q;
`ifdef IMM_ENCODER_SELFCHECK_EN
    logic [31:0] s1_imm;
    logic [2:0]  s1_src;
    logic [31:0] s2_imm_q;
    logic [2:0]  s2_src_q;
    logic        chk_fail_q;
    logic        chk_fail_d;
`endif

    imm_pack u_pack (
        .instr_i (in_instr),
        .imm_i   (in_imm),
        .src_i   (in_immsrc),
        .instr_o (pk_instr),
        .err_o   (pk_err)
    );

    assign s2_adv = ~out_valid_q | out_ready;

    generate
        if (PIPE_BYPASS) begin : g_bypass
            assign s1_valid = in_valid;
            assign s1_instr = pk_instr;
            assign s1_err   = pk_err;
            assign in_ready = s2_adv;
`ifdef IMM_ENCODER_SELFCHECK_EN
            assign s1_imm   = in_imm;
            assign s1_src   = in_immsrc;
`endif
        end else begin : g_s1
            logic        s1_adv;
            logic        s1_valid_q;
            logic [31:0] s1_instr_q;
            logic [1:0]  s1_err_q;
`ifdef IMM_ENCODER_SELFCHECK_EN
            logic [31:0] s1_imm_q;
            logic [2:0]  s1_src_q;
            assign s1_imm = s1_imm_q;
            assign s1_src = s1_src_q;
`endif
            assign s1_adv   = ~s1_valid_q | s2_adv;
            assign in_ready = s1_adv;
            assign s1_valid = s1_valid_q;
            assign s1_instr = s1_instr_q;
            assign s1_err   = s1_err_q;
            // S1 takes a new request whenever it is empty or S2 can absorb its current entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_valid_q <= 1'b0;
                    s1_instr_q <= 32'h0;
                    s1_err_q   <= 2'b00;
`ifdef IMM_ENCODER_SELFCHECK_EN
                    s1_imm_q   <= 32'h0;
                    s1_src_q   <= 3'b000;
`endif
                end else if (s1_adv) begin
                    s1_valid_q <= in_valid;
                    if (in_valid) begin
                        s1_instr_q <= pk_instr;
                        s1_err_q   <= pk_err;
`ifdef IMM_ENCODER_SELFCHECK_EN
                        s1_imm_q   <= in_imm;
                        s1_src_q   <= in_immsrc;
`endif
                    end
                end
            end
        end
    endgenerate

    // S2 output register holds steady under backpressure and refills as it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 2'b00;
`ifdef IMM_ENCODER_SELFCHECK_EN
            s2_imm_q    <= 32'h0;
            s2_src_q    <= 3'b000;
`endif
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_instr_q <= s1_instr;
                out_err_q   <= s1_err;
`ifdef IMM_ENCODER_SELFCHECK_EN
                s2_imm_q    <= s1_imm;
                s2_src_q    <= s1_src;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;

`ifdef IMM_ENCODER_SELFCHECK_EN
    assign chk_fail_d = chk_fail_q | (out_valid_q & out_ready & (out_err_q == ERR_OK) &
                        (imm_extend(out_instr_q, s2_src_q) != s2_imm_q));
    // Sticky flag: any delivered error-free word that does not decode back to its immediate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chk_fail_q <= 1'b0;
        else       chk_fail_q <= chk_fail_d;
    end
    assign chk_fail = chk_fail_q;
`else
    assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors plus a scoreboard fed by an arithmetic reference model
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [2:0]  in_immsrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic        chk_fail;

    int          compared = 0;
    int          mismatched = 0;
    int          out_count = 0;
    logic [33:0] exp_q[$];
    logic [33:0] sb_e;
    logic        stalled = 1'b0;
    logic        skip_sb = 1'b0;
    logic [31:0] held_instr;
    logic [1:0]  held_err;
    logic [31:0] st_ins[8];
    logic [31:0] st_imm[8];
    logic [2:0]  st_src[8];

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_imm    (in_imm),
        .in_immsrc (in_immsrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .chk_fail  (chk_fail)
    );

    // Reference: keep-masks of the non-immediate bits, fields built by shifting, ranges as signed integers
    function automatic logic [33:0] model(logic [31:0] ins, logic [31:0] imm, logic [2:0] src);
        int          v;
        logic [31:0] keep;
        logic [31:0] fld;
        logic [1:0]  e;
        v = $signed(imm);
        case (src)
            3'd0: begin
                keep = 32'h000F_FFFF;
                fld  = (imm & 32'hFFF) << 20;
                e    = (v < -2048 || v > 2047) ? 2'd1 : 2'd0;
            end
            3'd1: begin
                keep = 32'h01FF_F07F;
                fld  = ((imm >> 5) & 32'h7F) << 25 | (imm & 32'h1F) << 7;
                e    = (v < -2048 || v > 2047) ? 2'd1 : 2'd0;
            end
            3'd2: begin
                keep = 32'h01FF_F07F;
                fld  = ((imm >> 12) & 32'h1) << 31 | ((imm >> 5) & 32'h3F) << 25 |
                       ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 32'h1) << 7;
                e    = (imm % 2 != 0) ? 2'd2 : (v < -4096 || v > 4094) ? 2'd1 : 2'd0;
            end
            3'd3: begin
                keep = 32'h0000_0FFF;
                fld  = ((imm >> 20) & 32'h1) << 31 | ((imm >> 1) & 32'h3FF) << 21 |
                       ((imm >> 11) & 32'h1) << 20 | ((imm >> 12) & 32'hFF) << 12;
                e    = (imm % 2 != 0) ? 2'd2 : (v < -1048576 || v > 1048574) ? 2'd1 : 2'd0;
            end
            3'd4: begin
                keep = 32'h0000_0FFF;
                fld  = imm & 32'hFFFF_F000;
                e    = (imm % 4096 != 0) ? 2'd2 : 2'd0;
            end
            default: begin
                keep = 32'hFFFF_FFFF;
                fld  = 32'h0;
                e    = 2'd3;
            end
        endcase
        return {e, (ins & keep) | ((e == 2'd0) ? fld : 32'h0)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted request is modelled, every delivered result is checked in order
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && !skip_sb) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_instr", out_instr, held_instr);
                chk("stall_err", {30'h0, out_err}, {30'h0, held_err});
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_imm, in_immsrc));
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_spurious: output %h delivered with no request outstanding", out_instr);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (!skip_sb) begin
                        chk("sb_instr", out_instr, sb_e[31:0]);
                        chk("sb_err", {30'h0, out_err}, {30'h0, sb_e[33:32]});
                    end
                end
            end
            stalled    = out_valid && !out_ready;
            held_instr = out_instr;
            held_err   = out_err;
`ifndef IMM_ENCODER_SELFCHECK_EN
            chk("chk_fail_off", {31'h0, chk_fail}, 32'h0);
`endif
        end
    end

    task automatic send(logic [31:0] ins, logic [31:0] imm, logic [2:0] src);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_imm    = imm;
        in_immsrc = src;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Presented in the cycle after edge N, result must appear right after edge N+2
    task automatic lit(string nm, logic [31:0] ins, logic [31:0] imm, logic [2:0] src,
                       logic [31:0] xi, logic [1:0] xe);
        logic [33:0] m;
        m = model(ins, imm, src);
        chk({nm, "_model_instr"}, m[31:0], xi);
        chk({nm, "_model_err"}, {30'h0, m[33:32]}, {30'h0, xe});
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_imm    = imm;
        in_immsrc = src;
        chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({nm, "_lat1"}, {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk({nm, "_lat2"}, {31'h0, out_valid}, 32'h1);
        chk({nm, "_instr"}, out_instr, xi);
        chk({nm, "_err"}, {30'h0, out_err}, {30'h0, xe});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        st_ins = '{32'h0050_0513, 32'h00A1_2023, 32'h0020_8063, 32'h0000_006F,
                   32'h0000_0517, 32'h0000_0013, 32'h0000_00EF, 32'h0000_0023};
        st_imm = '{32'd100, 32'd2047, 32'hFFFF_F000, 32'hFFF0_0000,
                   32'hFFFF_F000, 32'hFFFF_F7FF, 32'd1048574, 32'd5};
        st_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd3, 3'd1};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_imm    = 32'h0;
        in_immsrc = 3'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", {30'h0, out_err}, 32'h0);
        chk("rst_chk_fail", {31'h0, chk_fail}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        lit("i_neg1", 32'h0000_0093, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0093, 2'b00);
        lit("s_neg4", 32'h0000_0023, 32'hFFFF_FFFC, 3'b001, 32'hFE00_0E23, 2'b00);
        lit("b_8", 32'h0000_0063, 32'd8, 3'b010, 32'h0000_0463, 2'b00);
        lit("j_800", 32'h0000_00EF, 32'h0000_0800, 3'b011, 32'h0010_00EF, 2'b00);
        lit("u_lui", 32'h0000_00B7, 32'h1234_5000, 3'b100, 32'h1234_50B7, 2'b00);
        lit("i_range", 32'h0000_0093, 32'd2048, 3'b000, 32'h0000_0093, 2'b01);
        lit("b_misalign", 32'h0000_0063, 32'd7, 3'b010, 32'h0000_0063, 2'b10);
        lit("b_mask", 32'hFFFF_FFFF, 32'd7, 3'b010, 32'h01FF_F07F, 2'b10);
        lit("illegal", 32'h1234_5678, 32'd4, 3'b111, 32'h1234_5678, 2'b11);
        lit("j_max", 32'h0000_006F, 32'd1048574, 3'b011, 32'h7FFF_F06F, 2'b00);

        @(posedge clk);
        #1 out_count = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(st_ins[i], st_imm[i], st_src[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_count", out_count, 32'd8);
        chk("bp_left", exp_q.size(), 32'd0);

        out_ready = 1'b0;
        send(32'h0000_0093, 32'd1, 3'b000);
        send(32'h0000_0093, 32'd2, 3'b000);
        chk("rstmid_pre_valid", {31'h0, out_valid}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("rstmid_valid", {31'h0, out_valid}, 32'h0);
        chk("rstmid_instr", out_instr, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_no_out", {31'h0, out_valid}, 32'h0);
        end

`ifdef IMM_ENCODER_SELFCHECK_EN
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h0000_0093, 32'd5, 3'b000);
        @(negedge clk);
        chk("sc_valid", {31'h0, out_valid}, 32'h1);
        chk("sc_clean", {31'h0, chk_fail}, 32'h0);
        skip_sb = 1'b1;
        force dut.out_instr_q = 32'h8050_0093;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        release dut.out_instr_q;
        skip_sb = 1'b0;
        chk("sc_set", {31'h0, chk_fail}, 32'h1);
        repeat (3) @(posedge clk);
        #1 chk("sc_sticky", {31'h0, chk_fail}, 32'h1);
        reset = 1'b1;
        #1 chk("sc_reset", {31'h0, chk_fail}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
